// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory port controller shared by instruction fetch and load/store buffer
module mem_ctrl #(
    parameter logic [1:0] IO_TAG = 2'b11,
    parameter bit         FAIR   = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // cnt is the index of the edge being processed relative to the grant edge E0
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic        owner_lsb;
    logic        last_lsb;

    logic        lsb_stalled;
    logic        cand_if;
    logic        cand_lsb;
    logic        grant_if;
    logic        grant_lsb;
    logic [31:0] grant_addr;
    logic [2:0]  lsb_n;
    logic        rd_last;
    logic        rd_sample;
    logic        addr_phase;
    logic [1:0]  byte_idx;
    logic [31:0] merged;
    logic [31:0] addr_off;
    logic [7:0]  wbyte;

    // Arbitration, next-state selection and per-edge datapath helpers
    always_comb begin
        lsb_stalled = lsb_wr && (lsb_addr[17:16] == IO_TAG) && io_buffer_full;
        cand_lsb    = lsb_req && !lsb_stalled;
        cand_if     = if_req;
        grant_lsb   = 1'b0;
        grant_if    = 1'b0;
        state_nxt   = state;

        if (cand_lsb && cand_if) begin
            if (FAIR && last_lsb) begin
                grant_if = 1'b1;
            end else begin
                grant_lsb = 1'b1;
            end
        end else if (cand_lsb) begin
            grant_lsb = 1'b1;
        end else if (cand_if) begin
            grant_if = 1'b1;
        end

        // A flush in IDLE suppresses the grant; outside IDLE there is nothing to grant
        if (clear || state != IDLE) begin
            grant_lsb = 1'b0;
            grant_if  = 1'b0;
        end

        case (lsb_len)
            2'd0:    lsb_n = 3'd1;
            2'd1:    lsb_n = 3'd2;
            default: lsb_n = 3'd4;
        endcase

        grant_addr = grant_lsb ? lsb_addr : if_addr;
        rd_last    = (cnt == len + 3'd1);
        rd_sample  = (cnt >= 3'd2);
        addr_phase = (cnt < len);
        byte_idx   = cnt[1:0] - 2'd2;
        merged     = rbuf | ({24'd0, mem_din} << {byte_idx, 3'b000});
        addr_off   = addr + {29'd0, cnt};
        wbyte      = wdata[{cnt[1:0], 3'b000} +: 8];

        case (state)
            IDLE: begin
                if (grant_lsb) begin
                    state_nxt = lsb_wr ? WRITE : READ;
                end else if (grant_if) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (clear) begin
                    state_nxt = IDLE;
                end else if (rd_last) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                // Stores are committed once granted, so a flush does not cut them short
                if (cnt == len) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, frozen while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    // Memory port sequencing, read assembly and done pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt       <= 3'd0;
            len       <= 3'd0;
            addr      <= 32'd0;
            wdata     <= 32'd0;
            rbuf      <= 32'd0;
            owner_lsb <= 1'b0;
            last_lsb  <= 1'b0;
            mem_a     <= 32'd0;
            mem_dout  <= 8'd0;
            mem_wr    <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= 32'd0;
            lsb_rdata <= 32'd0;
        end else if (rdy_in) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_lsb || grant_if) begin
                        last_lsb  <= grant_lsb;
                        owner_lsb <= grant_lsb;
                        addr      <= grant_addr;
                        mem_a     <= grant_addr;
                        len       <= grant_lsb ? lsb_n : 3'd4;
                        wdata     <= lsb_wdata;
                        rbuf      <= 32'd0;
                        cnt       <= 3'd1;
                        mem_wr    <= grant_lsb && lsb_wr;
                        if (grant_lsb && lsb_wr) begin
                            mem_dout <= lsb_wdata[7:0];
                        end
                    end
                end
                READ: begin
                    if (clear) begin
                        mem_a  <= 32'd0;
                        mem_wr <= 1'b0;
                    end else begin
                        cnt   <= cnt + 3'd1;
                        mem_a <= addr_phase ? addr_off : 32'd0;
                        // Data for the address driven at edge Ek arrives two edges later
                        if (rd_sample) begin
                            rbuf <= merged;
                        end
                        if (rd_last) begin
                            if (owner_lsb) begin
                                lsb_rdata <= merged;
                                lsb_done  <= 1'b1;
                            end else begin
                                if_data <= merged;
                                if_done <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    cnt <= cnt + 3'd1;
                    if (addr_phase) begin
                        mem_a    <= addr_off;
                        mem_dout <= wbyte;
                        mem_wr   <= 1'b1;
                    end else begin
                        mem_a    <= 32'd0;
                        mem_wr   <= 1'b0;
                        lsb_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard testbench for mem_ctrl
module tb_mem_ctrl;

    localparam int S_MEM_A     = 0;
    localparam int S_MEM_WR    = 1;
    localparam int S_MEM_DOUT  = 2;
    localparam int S_IF_DONE   = 3;
    localparam int S_LSB_DONE  = 4;
    localparam int S_IF_DATA   = 5;
    localparam int S_LSB_RDATA = 6;
    localparam int S_TIMEOUTS  = 7;
    localparam int S_QLEN      = 8;
    localparam int S_D0_LSB    = 9;
    localparam int S_D0_IF     = 10;

    typedef struct {
        int          c;
        int          sig;
        logic [31:0] v;
    } trace_t;

    typedef struct {
        bit          lsb;
        bit          store;
        logic [31:0] data;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        clear;
    logic        io_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    logic        if_req0;
    logic        lsb_req0;
    logic [7:0]  mem_dout0;
    logic [31:0] mem_a0;
    logic        mem_wr0;
    logic        if_done0;
    logic [31:0] if_data0;
    logic        lsb_done0;
    logic [31:0] lsb_rdata0;

    logic [7:0]  ram [0:8191];
    bit          ram_ready = 1'b0;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          timeouts = 0;
    int          lsb_cnt0 = 0;
    int          if_cnt0 = 0;
    bit          prev_done = 1'b0;
    trace_t      trace_q[$];
    done_t       done_q[$];
    trace_t      t;
    done_t       e;

    always #5 clk = ~clk;

    mem_ctrl #(.IO_TAG(2'b11), .FAIR(1'b1)) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear(clear),
        .io_buffer_full(io_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .lsb_req(lsb_req), .lsb_wr(lsb_wr),
        .lsb_addr(lsb_addr), .lsb_len(lsb_len), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    mem_ctrl #(.IO_TAG(2'b11), .FAIR(1'b0)) u_dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(1'b1), .clear(1'b0),
        .io_buffer_full(1'b0), .mem_din(8'h00), .mem_dout(mem_dout0),
        .mem_a(mem_a0), .mem_wr(mem_wr0), .if_req(if_req0), .if_addr(32'h0),
        .if_done(if_done0), .if_data(if_data0), .lsb_req(lsb_req0), .lsb_wr(1'b0),
        .lsb_addr(32'h0), .lsb_len(2'd2), .lsb_wdata(32'h0),
        .lsb_done(lsb_done0), .lsb_rdata(lsb_rdata0)
    );

    // RAM with one-cycle registered read
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 8192; i++) ram[i] <= 8'h00;
            ram[13'h0100] <= 8'h13;
            ram[13'h0101] <= 8'h05;
            ram[13'h1FFE] <= 8'h34;
            ram[13'h1FFF] <= 8'hF2;
            ram_ready <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[12:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[12:0]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int s);
        case (s)
            S_MEM_A:     return "mem_a";
            S_MEM_WR:    return "mem_wr";
            S_MEM_DOUT:  return "mem_dout";
            S_IF_DONE:   return "if_done";
            S_LSB_DONE:  return "lsb_done";
            S_IF_DATA:   return "if_data";
            S_LSB_RDATA: return "lsb_rdata";
            S_TIMEOUTS:  return "requester_timeouts";
            S_QLEN:      return "unserved_done_queue";
            S_D0_LSB:    return "fair0_lsb_dones_ge3";
            default:     return "fair0_if_dones";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_MEM_A:     return mem_a;
            S_MEM_WR:    return {31'd0, mem_wr};
            S_MEM_DOUT:  return {24'd0, mem_dout};
            S_IF_DONE:   return {31'd0, if_done};
            S_LSB_DONE:  return {31'd0, lsb_done};
            S_IF_DATA:   return if_data;
            S_LSB_RDATA: return lsb_rdata;
            S_TIMEOUTS:  return 32'(timeouts);
            S_QLEN:      return 32'(done_q.size());
            S_D0_LSB:    return {31'd0, lsb_cnt0 >= 3};
            default:     return 32'(if_cnt0);
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: timed trace checks plus in-order done scoreboard
    always @(negedge clk) begin
        if (lsb_done0) lsb_cnt0++;
        if (if_done0) if_cnt0++;
        while (trace_q.size() > 0 && trace_q[0].c <= cyc) begin
            t = trace_q.pop_front();
            cmp(sig_name(t.sig), sig_val(t.sig), t.v);
        end
        if (rst_n) begin
            if (if_done || lsb_done) begin
                cmp("done_single_pulse", {31'd0, (if_done && lsb_done) || prev_done}, 32'd0);
                cmp("done_pending", {31'd0, done_q.size() > 0}, 32'd1);
                if (done_q.size() > 0) begin
                    e = done_q.pop_front();
                    cmp("done_requester", {31'd0, lsb_done}, {31'd0, e.lsb});
                    if (!e.store) begin
                        cmp(e.lsb ? "lsb_load_data" : "if_fetch_data",
                            e.lsb ? lsb_rdata : if_data, e.data);
                    end
                end
            end
            prev_done = if_done || lsb_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic at(input int c, input int s, input logic [31:0] v);
        trace_t x;
        x.c = c;
        x.sig = s;
        x.v = v;
        trace_q.push_back(x);
    endtask

    task automatic exp_done(input bit lsb, input bit store, input logic [31:0] d);
        done_t x;
        x.lsb = lsb;
        x.store = store;
        x.data = d;
        done_q.push_back(x);
    endtask

    task automatic if_read(input logic [31:0] a);
        bit got;
        got = 1'b0;
        if_addr = a;
        if_req = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (if_done) got = 1'b1;
        end
        if (!got) timeouts++;
        @(posedge clk);
        #1 if_req = 1'b0;
    endtask

    task automatic lsb_op(input logic w, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
        bit got;
        got = 1'b0;
        lsb_wr = w;
        lsb_addr = a;
        lsb_len = l;
        lsb_wdata = d;
        lsb_req = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (lsb_done) got = 1'b1;
        end
        if (!got) timeouts++;
        @(posedge clk);
        #1 lsb_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [31:0] w;
        rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; io_full = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; lsb_req = 1'b0; lsb_wr = 1'b0;
        lsb_addr = 32'h0; lsb_len = 2'd0; lsb_wdata = 32'h0;
        if_req0 = 1'b0; lsb_req0 = 1'b0;

        // reset values
        at(2, S_MEM_A, 0); at(2, S_MEM_WR, 0); at(2, S_MEM_DOUT, 0); at(2, S_IF_DONE, 0);
        at(2, S_LSB_DONE, 0); at(2, S_IF_DATA, 0); at(2, S_LSB_RDATA, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // IF word read
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            at(e0 + k, S_MEM_A, 32'h100 + k);
            at(e0 + k, S_MEM_WR, 0);
        end
        at(e0 + 4, S_MEM_A, 0); at(e0 + 4, S_IF_DONE, 0);
        at(e0 + 5, S_IF_DONE, 1); at(e0 + 5, S_IF_DATA, 32'h0000_0513);
        at(e0 + 6, S_IF_DONE, 0);
        exp_done(0, 0, 32'h0000_0513);
        if_read(32'h100);

        // LSB half load, granted 7 edges after the previous grant
        e0 = cyc + 1;
        at(e0, S_MEM_A, 32'h1FFE); at(e0 + 1, S_MEM_A, 32'h1FFF); at(e0 + 2, S_MEM_A, 0);
        at(e0 + 2, S_LSB_DONE, 0); at(e0 + 3, S_LSB_DONE, 1); at(e0 + 3, S_LSB_RDATA, 32'h0000_F234);
        exp_done(1, 0, 32'h0000_F234);
        lsb_op(1'b0, 32'h1FFE, 2'd1, 32'h0);

        // word store and readback
        e0 = cyc + 1;
        w = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            at(e0 + k, S_MEM_A, 32'h200 + k);
            at(e0 + k, S_MEM_WR, 1);
            at(e0 + k, S_MEM_DOUT, {24'd0, w[8*k +: 8]});
        end
        at(e0 + 3, S_LSB_DONE, 0);
        at(e0 + 4, S_MEM_WR, 0); at(e0 + 4, S_MEM_A, 0); at(e0 + 4, S_LSB_DONE, 1);
        exp_done(1, 1, 32'h0);
        lsb_op(1'b1, 32'h200, 2'd2, w);
        exp_done(0, 0, 32'hDEAD_BEEF);
        if_read(32'h200);

        // conflict from reset: FAIR=1 alternates starting with LSB, FAIR=0 always LSB
        rst_n = 1'b0;
        if_req0 = 1'b1; lsb_req0 = 1'b1;
        exp_done(1, 0, 32'h0000_F234);
        exp_done(0, 0, 32'h0000_0513);
        exp_done(1, 0, 32'h0000_F234);
        exp_done(0, 0, 32'h0000_0513);
        fork
            begin if_read(32'h100); if_read(32'h100); end
            begin lsb_op(1'b0, 32'h1FFE, 2'd1, 32'h0); lsb_op(1'b0, 32'h1FFE, 2'd1, 32'h0); end
            begin repeat (2) @(posedge clk); #1 rst_n = 1'b1; end
        join
        repeat (10) @(posedge clk);
        #1 if_req0 = 1'b0; lsb_req0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // IO store stalled while the buffer is full; IF proceeds meanwhile
        e0 = cyc;
        at(e0 + 1, S_MEM_A, 32'h100); at(e0 + 1, S_MEM_WR, 0);
        at(e0 + 7, S_MEM_WR, 0);
        at(e0 + 8, S_MEM_A, 32'h30000); at(e0 + 8, S_MEM_WR, 1); at(e0 + 8, S_MEM_DOUT, 32'h5A);
        at(e0 + 9, S_LSB_DONE, 1);
        exp_done(0, 0, 32'h0000_0513);
        exp_done(1, 1, 32'h0);
        fork
            if_read(32'h100);
            lsb_op(1'b1, 32'h30000, 2'd0, 32'h0000_005A);
            begin io_full = 1'b1; repeat (5) @(posedge clk); #1 io_full = 1'b0; end
        join

        // IO store alone: no grant until the first IDLE edge after full drops
        e0 = cyc;
        for (int k = 1; k <= 5; k++) at(e0 + k, S_MEM_WR, 0);
        at(e0 + 6, S_MEM_A, 32'h30001); at(e0 + 6, S_MEM_WR, 1); at(e0 + 6, S_MEM_DOUT, 32'hA5);
        at(e0 + 7, S_LSB_DONE, 1); at(e0 + 7, S_MEM_WR, 0);
        exp_done(1, 1, 32'h0);
        fork
            lsb_op(1'b1, 32'h30001, 2'd0, 32'h0000_00A5);
            begin io_full = 1'b1; repeat (5) @(posedge clk); #1 io_full = 1'b0; end
        join

        // clear during an IF read: no done, data kept, back to IDLE
        e0 = cyc + 1;
        at(e0 + 2, S_MEM_A, 32'h202);
        at(e0 + 3, S_MEM_A, 0); at(e0 + 3, S_MEM_WR, 0); at(e0 + 3, S_IF_DONE, 0);
        at(e0 + 4, S_MEM_A, 0);
        for (int k = 4; k <= 7; k++) at(e0 + k, S_IF_DONE, 0);
        at(e0 + 7, S_IF_DATA, 32'h0000_0513);
        if_addr = 32'h200; if_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; if_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // clear during a word store: the store still completes
        e0 = cyc + 1;
        w = 32'hCAFE_F00D;
        at(e0 + 2, S_MEM_A, 32'h302);
        at(e0 + 3, S_MEM_A, 32'h303); at(e0 + 3, S_MEM_DOUT, 32'hCA); at(e0 + 3, S_MEM_WR, 1);
        at(e0 + 4, S_LSB_DONE, 1); at(e0 + 4, S_MEM_WR, 0);
        exp_done(1, 1, 32'h0);
        fork
            lsb_op(1'b1, 32'h300, 2'd2, w);
            begin @(posedge clk); @(posedge clk); #1 clear = 1'b1; @(posedge clk); #1 clear = 1'b0; end
        join
        exp_done(0, 0, 32'hCAFE_F00D);
        if_read(32'h300);

        // asynchronous reset in the middle of a read
        e0 = cyc + 1;
        at(e0 + 2, S_MEM_A, 32'h102);
        at(e0 + 3, S_MEM_A, 0); at(e0 + 3, S_MEM_WR, 0); at(e0 + 3, S_MEM_DOUT, 0);
        at(e0 + 3, S_IF_DONE, 0); at(e0 + 3, S_LSB_DONE, 0);
        at(e0 + 3, S_IF_DATA, 0); at(e0 + 3, S_LSB_RDATA, 0);
        if_addr = 32'h100; if_req = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 if_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // closing checks
        e0 = cyc + 1;
        at(e0, S_TIMEOUTS, 0);
        at(e0, S_QLEN, 0);
        at(e0, S_D0_LSB, 1);
        at(e0, S_D0_IF, 0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
